// File: rtl/unidade_controle_pkg.sv
// ---------------------------------------------------------------------------
// unidade_controle_pkg
// Shared processor definitions used by the control unit:
//   - opcode constants carried in IR[8:6]
//   - step (FSM state) encoding T0..T3
// ---------------------------------------------------------------------------
package unidade_controle_pkg;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } step_e;

endpackage

// File: rtl/unidade_controle_dec3to8.sv
// ---------------------------------------------------------------------------
// dec3to8
// 3-to-8 one-hot decoder with enable.
//   w_i  : 3-bit register index
//   en_i : decoder enable; output is all zero when low
//   y_o  : one-hot result, bit w_i set when enabled
// ---------------------------------------------------------------------------
module dec3to8 (
    input  logic [2:0] w_i,
    input  logic       en_i,
    output logic [7:0] y_o
);

    always_comb begin
        y_o = '0;
        if (en_i) begin
            y_o[w_i] = 1'b1;
        end
    end

endmodule

// File: rtl/unidade_controle.sv
// ---------------------------------------------------------------------------
// unidade_controle
// Step-sequenced control unit of a simple multi-cycle processor.
// A 2-bit step register (T0..T3) plus combinational decode of IR produce
// the register-file, ALU and bus control strobes.
//   Clock  : system clock, rising edge
//   Resetn : asynchronous active-low reset
//   Run    : start request, sampled only in T0
//   IR     : instruction {opcode[8:6], X[5:3], Y[2:0]}
//   Rin    : one-hot register load enables
//   Rout   : one-hot register bus-drive selects
//   IRin, Ain, Gin : load enables for IR, A, G
//   DINout, Gout   : bus-drive selects for DIN and G
//   AddSub : ALU op (0 add, 1 subtract)
//   Done   : high in the final step of an instruction
// ---------------------------------------------------------------------------
module unidade_controle
    import unidade_controle_pkg::*;
#(
    parameter int unsigned NREGS = 8,
    parameter int unsigned OPW   = 3
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Run,
    input  logic [8:0]       IR,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic             IRin,
    output logic             Ain,
    output logic             Gin,
    output logic             DINout,
    output logic             Gout,
    output logic             AddSub,
    output logic             Done
);

    step_e step_q;
    step_e step_d;

    logic [OPW-1:0]   op;
    logic [7:0]       x_oh;
    logic [7:0]       y_oh;
    logic [NREGS-1:0] x_sel;
    logic [NREGS-1:0] y_sel;
    logic             is_alu;
    logic             rin_x;
    logic             rout_x;
    logic             rout_y;

    assign op     = IR[8 -: OPW];
    assign is_alu = (op == OPW'(OP_ADD)) || (op == OPW'(OP_SUB));

    dec3to8 u_dec_x (
        .w_i  (IR[5:3]),
        .en_i (1'b1),
        .y_o  (x_oh)
    );

    dec3to8 u_dec_y (
        .w_i  (IR[2:0]),
        .en_i (1'b1),
        .y_o  (y_oh)
    );

    assign x_sel = NREGS'(x_oh);
    assign y_sel = NREGS'(y_oh);

    always_comb begin
        step_d = step_q;
        unique case (step_q)
            T0: step_d = Run ? T1 : T0;
            T1: step_d = is_alu ? T2 : T0;
            T2: step_d = T3;
            T3: step_d = T0;
            default: step_d = T0;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            step_q <= T0;
        end else begin
            step_q <= step_d;
        end
    end

    always_comb begin
        rin_x  = 1'b0;
        rout_x = 1'b0;
        rout_y = 1'b0;
        IRin   = 1'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        DINout = 1'b0;
        Gout   = 1'b0;
        AddSub = 1'b0;
        Done   = 1'b0;
        unique case (step_q)
            // Reset forces T0 asynchronously; gating IRin with Resetn keeps
            // every output low while reset is held, whatever Run does.
            T0: IRin = Run & Resetn;
            T1: begin
                if (op == OPW'(OP_MV)) begin
                    rout_y = 1'b1;
                    rin_x  = 1'b1;
                    Done   = 1'b1;
                end else if (op == OPW'(OP_MVI)) begin
                    DINout = 1'b1;
                    rin_x  = 1'b1;
                    Done   = 1'b1;
                end else if (is_alu) begin
                    rout_x = 1'b1;
                    Ain    = 1'b1;
                end else begin
                    Done   = 1'b1;
                end
            end
            T2: begin
                rout_y = 1'b1;
                Gin    = 1'b1;
                AddSub = IR[6];
            end
            T3: begin
                Gout  = 1'b1;
                rin_x = 1'b1;
                Done  = 1'b1;
            end
            default: ;
        endcase
    end

    assign Rin  = rin_x  ? x_sel : '0;
    assign Rout = rout_x ? x_sel : (rout_y ? y_sel : '0);

endmodule

// File: tb/tb_unidade_controle.sv
module tb_unidade_controle;

    typedef struct packed {
        logic [7:0] rin;
        logic [7:0] rout;
        logic       irin;
        logic       ain;
        logic       gin;
        logic       dinout;
        logic       gout;
        logic       addsub;
        logic       done;
    } exp_t;

    localparam exp_t ZERO = '0;

    logic       Clock;
    logic       Resetn;
    logic       Run;
    logic [8:0] IR;
    logic [7:0] Rin;
    logic [7:0] Rout;
    logic       IRin, Ain, Gin, DINout, Gout, AddSub, Done;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    unidade_controle #(.NREGS(8), .OPW(3)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Run    (Run),
        .IR     (IR),
        .Rin    (Rin),
        .Rout   (Rout),
        .IRin   (IRin),
        .Ain    (Ain),
        .Gin    (Gin),
        .DINout (DINout),
        .Gout   (Gout),
        .AddSub (AddSub),
        .Done   (Done)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic exp_t ex(input logic [7:0] rin, input logic [7:0] rout,
                                input logic irin, input logic ain, input logic gin,
                                input logic dinout, input logic gout,
                                input logic addsub, input logic done);
        exp_t e;
        e.rin = rin; e.rout = rout; e.irin = irin; e.ain = ain; e.gin = gin;
        e.dinout = dinout; e.gout = gout; e.addsub = addsub; e.done = done;
        return e;
    endfunction

    task automatic push(input exp_t e);
        sb.push_back(e);
    endtask

    task automatic do_check(input string tag);
        exp_t o;
        exp_t e;
        o = ex(Rin, Rout, IRin, Ain, Gin, DINout, Gout, AddSub, Done);
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s: scoreboard empty, observed=%h", tag, o);
        end else begin
            e = sb.pop_front();
            assert (o === e) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", tag, o, e);
            end
        end
        total++;
        assert ($countones({Rout, DINout, Gout}) <= 1) else begin
            bad++;
            $error("FAIL %s_bus: drivers observed=%b expected at most one", tag, {Rout, DINout, Gout});
        end
        total++;
        assert ($countones(Rin) <= 1) else begin
            bad++;
            $error("FAIL %s_rin: Rin observed=%b expected at most one-hot", tag, Rin);
        end
    endtask

    // Compare on the falling edge, then advance just past the next rising edge.
    task automatic check_cycle(input string tag);
        @(negedge Clock);
        do_check(tag);
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Resetn = 1'b1;
        Run    = 1'b1;
        IR     = '0;
        #1 Resetn = 1'b0;
        #2;
        push(ZERO); do_check("reset_async");
        @(posedge Clock);
        @(posedge Clock);
        #1;
        push(ZERO); check_cycle("reset_hold");

        // mvi R2,#5
        Resetn = 1'b1; IR = 9'b001_010_000; Run = 1'b1;
        push(ex(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0)); check_cycle("mvi_t0");
        Run = 1'b0;
        push(ex(8'h04, 8'h00, 0, 0, 0, 1, 0, 0, 1)); check_cycle("mvi_t1");
        push(ZERO); check_cycle("mvi_idle");

        // mv R0,R7
        IR = 9'b000_000_111; Run = 1'b1;
        push(ex(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0)); check_cycle("mv_t0");
        Run = 1'b0;
        push(ex(8'h01, 8'h80, 0, 0, 0, 0, 0, 0, 1)); check_cycle("mv_t1");

        // sub R1,R4 with Run toggled mid-instruction (must be ignored)
        IR = 9'b011_001_100; Run = 1'b1;
        push(ex(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0)); check_cycle("sub_t0");
        Run = 1'b0;
        push(ex(8'h00, 8'h02, 0, 1, 0, 0, 0, 0, 0)); check_cycle("sub_t1");
        Run = 1'b1;
        push(ex(8'h00, 8'h10, 0, 0, 1, 0, 0, 1, 0)); check_cycle("sub_t2");
        push(ex(8'h02, 8'h00, 0, 0, 0, 0, 1, 0, 1)); check_cycle("sub_t3");
        Run = 1'b0;
        push(ZERO); check_cycle("sub_idle");

        // add R5,R5 (X == Y)
        IR = 9'b010_101_101; Run = 1'b1;
        push(ex(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0)); check_cycle("add_t0");
        Run = 1'b0;
        push(ex(8'h00, 8'h20, 0, 1, 0, 0, 0, 0, 0)); check_cycle("add_t1");
        push(ex(8'h00, 8'h20, 0, 0, 1, 0, 0, 0, 0)); check_cycle("add_t2");
        push(ex(8'h20, 8'h00, 0, 0, 0, 0, 1, 0, 1)); check_cycle("add_t3");

        // mv R3,R3
        IR = 9'b000_011_011; Run = 1'b1;
        push(ex(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0)); check_cycle("mv33_t0");
        Run = 1'b0;
        push(ex(8'h08, 8'h08, 0, 0, 0, 0, 0, 0, 1)); check_cycle("mv33_t1");

        // opcode 110 is a NOP
        IR = 9'b110_010_011; Run = 1'b1;
        push(ex(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0)); check_cycle("nop_t0");
        Run = 1'b0;
        push(ex(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1)); check_cycle("nop_t1");
        push(ZERO); check_cycle("nop_idle");

        // back-to-back: mvi R2 then add R1,R2 with Run held high
        IR = 9'b001_010_000; Run = 1'b1;
        push(ex(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0)); check_cycle("b2b_c1");
        push(ex(8'h04, 8'h00, 0, 0, 0, 1, 0, 0, 1)); check_cycle("b2b_c2");
        IR = 9'b010_001_010;
        push(ex(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0)); check_cycle("b2b_c3");
        push(ex(8'h00, 8'h02, 0, 1, 0, 0, 0, 0, 0)); check_cycle("b2b_c4");
        push(ex(8'h00, 8'h04, 0, 0, 1, 0, 0, 0, 0)); check_cycle("b2b_c5");
        Run = 1'b0;
        push(ex(8'h02, 8'h00, 0, 0, 0, 0, 1, 0, 1)); check_cycle("b2b_c6");
        push(ZERO); check_cycle("b2b_idle");

        // reset in T2 of add R3,R1
        IR = 9'b010_011_001; Run = 1'b1;
        push(ex(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0)); check_cycle("rst_t0");
        Run = 1'b0;
        push(ex(8'h00, 8'h08, 0, 1, 0, 0, 0, 0, 0)); check_cycle("rst_t1");
        @(negedge Clock);
        push(ex(8'h00, 8'h02, 0, 0, 1, 0, 0, 0, 0)); do_check("rst_t2");
        #1 Resetn = 1'b0; Run = 1'b1;
        #1 push(ZERO); do_check("rst_async_zero");
        @(posedge Clock);
        #1;
        push(ZERO); do_check("rst_hold_run");
        Resetn = 1'b1; IR = 9'b001_110_000; Run = 1'b1;
        push(ex(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0)); check_cycle("rst_rel_t0");
        Run = 1'b0;
        push(ex(8'h40, 8'h00, 0, 0, 0, 1, 0, 0, 1)); check_cycle("rst_rel_t1");

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_drain: leftover observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 Parameter NREGS, default 8, number of general registers driven (Rin/Rout width).
REQ-002 Parameter OPW, default 3, opcode field width in IR.
REQ-003 Clock  input  1  system clock; all state changes on rising edge.
REQ-004 Resetn  input  1  asynchronous, active-low reset.
REQ-005 Run  input  1  start request; sampled only in step T0.
REQ-006 IR  input  9  current instruction from IR register: IR[8:6]=opcode, IR[5:3]=X, IR[2:0]=Y.
REQ-007 Rin  output  NREGS  one-hot load enables to registers R0..R7 (bit i drives RIn of Ri).
REQ-008 Rout  output  NREGS  one-hot bus-drive selects for R0..R7.
REQ-009 IRin, Ain, Gin  output  1 each  load enables for IR, A, G registers.
REQ-010 DINout, Gout  output  1 each  bus-drive selects for DIN and G.
REQ-011 AddSub  output  1  ALU op: 0 = add, 1 = subtract.
REQ-012 Done  output  1  high for exactly the final step of an instruction.

Function
REQ-013 Controller SHALL be a 4-state step FSM: T0, T1, T2, T3; outputs combinational from state and IR.
REQ-014 T0: IRin = Run; next = T1 if Run=1, else T0; all other outputs 0.
REQ-015 Opcode 000 (mv Rx,Ry) in T1: Rout[Y]=1, Rin[X]=1, Done=1; next T0.
REQ-016 Opcode 001 (mvi Rx,#D) in T1: DINout=1, Rin[X]=1, Done=1; next T0.
REQ-017 Opcodes 010 (add) / 011 (sub) in T1: Rout[X]=1, Ain=1; next T2.
REQ-018 add/sub in T2: Rout[Y]=1, Gin=1, AddSub = IR[6]; next T3.
REQ-019 add/sub in T3: Gout=1, Rin[X]=1, Done=1; next T0.
REQ-020 Opcodes 100-111 SHALL be NOP: T1 asserts Done only; next T0.
REQ-021 Latency: mv/mvi/NOP 2 cycles, add/sub 4 cycles, counted from the T0 edge where Run=1.
REQ-022 At most one of Rout bits, DINout, Gout SHALL be high in any cycle (single bus driver).
REQ-023 At most one Rin bit SHALL be high in any cycle; Rin and Ain/Gin/IRin never high together except as listed.
REQ-024 X=Y SHALL be legal: mv R3,R3 drives Rout[3] and Rin[3] same cycle.
REQ-025 Run changes after T0 SHALL be ignored; instruction always completes.
REQ-026 Run held high SHALL start the next instruction in the cycle after Done (back-to-back, no idle step).
REQ-027 IR SHALL be treated as stable from T1 to instruction end; IR changes mid-instruction are not guarded.

Reset
REQ-028 Resetn=0 SHALL force state T0 immediately, independent of Clock.
REQ-029 While Resetn=0 all outputs SHALL be 0, including IRin regardless of Run.
REQ-030 Reset mid-instruction SHALL abort it; no further Rin/Gin/Ain pulse after Resetn falls.
REQ-031 After Resetn rises, first Clock edge with Run=1 SHALL enter T1.

Structure
REQ-032 Opcode constants (MV, MVI, ADD, SUB) and step encodings T0..T3 SHALL reside in the shared processor package.
REQ-033 X/Y one-hot decoding SHALL use one sub-module, dec3to8 (3-bit in, enable, 8-bit one-hot out), instanced twice.
REQ-034 State register SHALL be 2 bits; no other storage in the block.

Verification
REQ-035 Reset: Resetn=0 mid-T2 of add -> all outputs 0 within same cycle; after release, Run=1 -> T1 next edge.
REQ-036 mvi R2,#5 (IR=001_010_000, Run=1) -> T0 IRin=1; T1 DINout=1, Rin=8'b00000100, Done=1; back in T0.
REQ-037 mv R0,R7 (IR=000_000_111) -> T1 Rout=8'b10000000, Rin=8'b00000001, Done=1.
REQ-038 sub R1,R4 (IR=011_001_100) -> T1 Rout[1],Ain; T2 Rout[4],Gin,AddSub=1; T3 Gout,Rin[1],Done; add variant AddSub=0.
REQ-039 Run=1 continuously with mvi then add -> Done pulses at cycles 2 and 6, no idle step between.
REQ-040 All cycles of all scenarios -> checker confirms single bus driver and Rin at most one-hot; opcode 110 -> Done in T1, no enables.
